// File: rtl/pci_pkg.sv
// Shared definitions for the PCI target: bus commands, FSM state
// encoding and the byte-lane merge used by the register file.
package pci_pkg;

    // Bus commands presented on C/BE# during the address phase.
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    // Target FSM state encoding.
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_BUS_BUSY   = 3'd1;
    localparam logic [2:0] ST_WR_DATA    = 3'd2;
    localparam logic [2:0] ST_RD_TA      = 3'd3;
    localparam logic [2:0] ST_RD_DATA    = 3'd4;
    localparam logic [2:0] ST_TURNAROUND = 3'd5;

    // Replace only the byte lanes whose enable is high. C/BE# carries four
    // lanes, so a data word is always 32 bits on this bus.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/pci_target_regfile.sv
// Word-addressed register file behind the target window: byte-enable
// write on the clock edge, combinational read. Contents are not reset.
import pci_pkg::*;

module pci_target_regfile #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [3:0]            i_be,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];

    // Byte-lane write of the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= be_merge(r_mem[i_addr], i_wdata, i_be);
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI target control: decodes memory read/write hits on the sampled bus,
// sequences DEVSEL#/TRDY#/STOP# and read data, and moves burst data to and
// from the register file. Every driven value is paired with an active-low
// enable for the pad tri-state drivers.
//
// Handshake: a data transfer happens on a rising edge where irdy_n==0 and
// trdy_n_out==0; either side high is a wait state and nothing advances.
import pci_pkg::*;

module pci_target_ctrl #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int               DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_n,
    input  logic             irdy_n,
    input  logic [WIDTH-1:0] ad_in,
    input  logic [3:0]       cbe_n,
    output logic [WIDTH-1:0] ad_out,
    output logic             ad_oe_n,
    output logic             devsel_n_out,
    output logic             trdy_n_out,
    output logic             stop_n_out,
    output logic             ctl_oe_n,
    output logic             hit
);

    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    logic [2:0]            r_state;
    logic                  r_disc;       // disconnect pending: STOP# low, TRDY# high
    logic                  r_prev_frame_n;
    logic [DEPTH_LOG2-1:0] r_index;
    logic                  r_hit;

    logic [2:0]            w_state_nxt;
    logic                  w_disc_nxt;
    logic                  w_addr_phase;
    logic                  w_win_hit;
    logic                  w_claim;
    logic                  w_data_st;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_we;
    logic [WIDTH-1:0]      w_rd_data;
    logic                  w_unused_ad;

    // Address-phase decode: a FRAME# falling edge seen from IDLE.
    assign w_addr_phase = (r_state == ST_IDLE) && !frame_n && r_prev_frame_n;
    assign w_win_hit    = ad_in[WIDTH-1:DEPTH_LOG2+2] == BASE_ADDR[WIDTH-1:DEPTH_LOG2+2];
    assign w_claim      = w_addr_phase && w_win_hit &&
                          ((cbe_n == CMD_MEM_RD) || (cbe_n == CMD_MEM_WR));
    assign w_data_st    = (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA);
    assign w_xfer       = w_data_st && !r_disc && !irdy_n;
    assign w_last       = (r_index == LAST_IDX);
    assign w_we         = w_xfer && (r_state == ST_WR_DATA);
    assign w_unused_ad  = ^ad_in[1:0];

    pci_target_regfile #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regfile (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  (r_index),
        .i_wdata (ad_in),
        .i_be    (~cbe_n),
        .o_rdata (w_rd_data)
    );

    // State register with the disconnect flag that qualifies the data states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_disc  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_disc  <= w_disc_nxt;
        end
    end

    // Datapath registers: FRAME# history, burst word index, claim pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_frame_n <= 1'b1;
            r_index        <= '0;
            r_hit          <= 1'b0;
        end else begin
            r_prev_frame_n <= frame_n;
            r_hit          <= w_claim;
            if (w_claim) begin
                r_index <= ad_in[DEPTH_LOG2+1:2];
            end else if (w_xfer && !w_last) begin
                r_index <= r_index + 1'b1;  // never wraps past the window end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_disc_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_claim) begin
                    w_state_nxt = (cbe_n == CMD_MEM_WR) ? ST_WR_DATA : ST_RD_TA;
                end else if (w_addr_phase) begin
                    w_state_nxt = ST_BUS_BUSY;
                end
            end
            ST_BUS_BUSY: begin
                if (frame_n && irdy_n) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_TA: begin
                w_state_nxt = ST_RD_DATA;
            end
            ST_WR_DATA, ST_RD_DATA: begin
                if (r_disc) begin
                    // Wait for the master to drop FRAME# after our STOP#.
                    if (frame_n) begin
                        w_state_nxt = ST_TURNAROUND;
                    end else begin
                        w_disc_nxt = 1'b1;
                    end
                end else if (w_xfer) begin
                    if (frame_n) begin
                        w_state_nxt = ST_TURNAROUND;
                    end else if (w_last) begin
                        w_disc_nxt = 1'b1;
                    end
                end
            end
            ST_TURNAROUND: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state (releases at once on reset).
    always_comb begin
        ad_out       = '0;
        ad_oe_n      = 1'b1;
        devsel_n_out = 1'b1;
        trdy_n_out   = 1'b1;
        stop_n_out   = 1'b1;
        ctl_oe_n     = 1'b1;
        hit          = r_hit;
        case (r_state)
            ST_WR_DATA: begin
                ctl_oe_n     = 1'b0;
                devsel_n_out = 1'b0;
                trdy_n_out   = r_disc;
                stop_n_out   = !r_disc;
            end
            ST_RD_TA: begin
                ctl_oe_n     = 1'b0;
                devsel_n_out = 1'b0;
            end
            ST_RD_DATA: begin
                ctl_oe_n     = 1'b0;
                devsel_n_out = 1'b0;
                trdy_n_out   = r_disc;
                stop_n_out   = !r_disc;
                ad_oe_n      = 1'b0;
                ad_out       = w_rd_data;
            end
            ST_TURNAROUND: begin
                ctl_oe_n = 1'b0;
            end
            default: begin
                ctl_oe_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Directed bench for pci_target_ctrl: single and burst memory writes and
// reads, window-end disconnect, unclaimed transactions and mid-burst reset.
import pci_pkg::*;

module tb_pci_target_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_n;
    logic        irdy_n;
    logic [31:0] ad_in;
    logic [3:0]  cbe_n;
    logic [31:0] ad_out;
    logic        ad_oe_n;
    logic        devsel_n_out;
    logic        trdy_n_out;
    logic        stop_n_out;
    logic        ctl_oe_n;
    logic        hit;

    int n_checks = 0;
    int n_fail   = 0;

    pci_target_ctrl #(
        .WIDTH      (32),
        .BASE_ADDR  (32'h1000_0000),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_n      (frame_n),
        .irdy_n       (irdy_n),
        .ad_in        (ad_in),
        .cbe_n        (cbe_n),
        .ad_out       (ad_out),
        .ad_oe_n      (ad_oe_n),
        .devsel_n_out (devsel_n_out),
        .trdy_n_out   (trdy_n_out),
        .stop_n_out   (stop_n_out),
        .ctl_oe_n     (ctl_oe_n),
        .hit          (hit)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an address phase and step into cycle A+1.
    task automatic addr_phase(input logic [31:0] addr, input logic [3:0] cmd);
        frame_n = 1'b0;
        irdy_n  = 1'b1;
        ad_in   = addr;
        cbe_n   = cmd;
        tick();
    endtask

    // Complete single-beat write (address phase through release).
    task automatic single_write(input logic [31:0] addr, input logic [31:0] data);
        addr_phase(addr, CMD_MEM_WR);
        ad_in   = data;
        cbe_n   = 4'h0;
        irdy_n  = 1'b0;
        frame_n = 1'b1;
        tick();
        irdy_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        ad_in   = '0;
        cbe_n   = 4'hF;
        #1;
        // Reset state
        chk("rst_ctl_oe_n", {31'd0, ctl_oe_n}, 32'd1);
        chk("rst_ad_oe_n",  {31'd0, ad_oe_n},  32'd1);
        chk("rst_devsel",   {31'd0, devsel_n_out}, 32'd1);
        chk("rst_trdy",     {31'd0, trdy_n_out}, 32'd1);
        chk("rst_stop",     {31'd0, stop_n_out}, 32'd1);
        chk("rst_hit",      {31'd0, hit}, 32'd0);
        chk("rst_ad_out",   ad_out, 32'd0);
        chk("rst_state",    {29'd0, dut.r_state}, {29'd0, ST_IDLE});
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single write to 0x1000_0004
        addr_phase(32'h1000_0004, CMD_MEM_WR);
        chk("wr1_devsel", {31'd0, devsel_n_out}, 32'd0);
        chk("wr1_trdy",   {31'd0, trdy_n_out}, 32'd0);
        chk("wr1_ctl_oe", {31'd0, ctl_oe_n}, 32'd0);
        chk("wr1_hit",    {31'd0, hit}, 32'd1);
        ad_in   = 32'hDEAD_BEEF;
        cbe_n   = 4'h0;
        irdy_n  = 1'b0;
        frame_n = 1'b1;
        tick();
        chk("wr1_ta_ctl_oe", {31'd0, ctl_oe_n}, 32'd0);
        chk("wr1_ta_devsel", {31'd0, devsel_n_out}, 32'd1);
        chk("wr1_ta_trdy",   {31'd0, trdy_n_out}, 32'd1);
        chk("wr1_ta_stop",   {31'd0, stop_n_out}, 32'd1);
        chk("wr1_ta_hit",    {31'd0, hit}, 32'd0);
        irdy_n = 1'b1;
        tick();
        chk("wr1_release", {31'd0, ctl_oe_n}, 32'd1);
        chk("wr1_idle",    {29'd0, dut.r_state}, {29'd0, ST_IDLE});
        chk("wr1_mem1",    dut.u_regfile.r_mem[1], 32'hDEAD_BEEF);

        // Single read of 0x1000_0004
        addr_phase(32'h1000_0004, CMD_MEM_RD);
        chk("rd1_ta_ad_oe",  {31'd0, ad_oe_n}, 32'd1);
        chk("rd1_ta_devsel", {31'd0, devsel_n_out}, 32'd0);
        chk("rd1_ta_trdy",   {31'd0, trdy_n_out}, 32'd1);
        chk("rd1_ta_ctl_oe", {31'd0, ctl_oe_n}, 32'd0);
        chk("rd1_hit",       {31'd0, hit}, 32'd1);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        ad_in   = '0;
        cbe_n   = 4'h0;
        tick();
        chk("rd1_ad_oe",  {31'd0, ad_oe_n}, 32'd0);
        chk("rd1_ad_out", ad_out, 32'hDEAD_BEEF);
        chk("rd1_trdy",   {31'd0, trdy_n_out}, 32'd0);
        tick();
        chk("rd1_end_ad_oe",  {31'd0, ad_oe_n}, 32'd1);
        chk("rd1_end_devsel", {31'd0, devsel_n_out}, 32'd1);
        chk("rd1_end_ctl_oe", {31'd0, ctl_oe_n}, 32'd0);
        irdy_n = 1'b1;
        tick();
        chk("rd1_release", {31'd0, ctl_oe_n}, 32'd1);

        // Preload words for the partial-lane and window-end cases
        single_write(32'h1000_000C, 32'hAAAA_AAAA);
        single_write(32'h1000_003C, 32'hCAFE_F00D);
        chk("pre_mem3",  dut.u_regfile.r_mem[3],  32'hAAAA_AAAA);
        chk("pre_mem15", dut.u_regfile.r_mem[15], 32'hCAFE_F00D);

        // 3-beat write burst from 0x1000_0008 with a wait before beat 3
        addr_phase(32'h1000_0008, CMD_MEM_WR);
        ad_in  = 32'h1111_1111;
        cbe_n  = 4'h0;
        irdy_n = 1'b0;
        tick();
        ad_in = 32'h2222_2222;
        cbe_n = 4'b1100;
        tick();
        irdy_n = 1'b1;
        ad_in  = 32'h9999_9999;
        cbe_n  = 4'h0;
        tick();
        chk("bw_wait_index", {28'd0, dut.r_index}, 32'd4);
        chk("bw_wait_trdy",  {31'd0, trdy_n_out}, 32'd0);
        tick();
        chk("bw_wait2_index", {28'd0, dut.r_index}, 32'd4);
        irdy_n  = 1'b0;
        frame_n = 1'b1;
        ad_in   = 32'h3333_3333;
        tick();
        chk("bw_ta_devsel", {31'd0, devsel_n_out}, 32'd1);
        irdy_n = 1'b1;
        tick();
        chk("bw_mem2", dut.u_regfile.r_mem[2], 32'h1111_1111);
        chk("bw_mem3", dut.u_regfile.r_mem[3], 32'hAAAA_2222);
        chk("bw_mem4", dut.u_regfile.r_mem[4], 32'h3333_3333);
        chk("bw_release", {31'd0, ctl_oe_n}, 32'd1);

        // Read burst at the last word with FRAME# held: disconnect-with-data
        addr_phase(32'h1000_003C, CMD_MEM_RD);
        irdy_n = 1'b0;
        tick();
        chk("disc_ad_out", ad_out, 32'hCAFE_F00D);
        chk("disc_trdy",   {31'd0, trdy_n_out}, 32'd0);
        chk("disc_stop0",  {31'd0, stop_n_out}, 32'd1);
        tick();
        chk("disc_stop",   {31'd0, stop_n_out}, 32'd0);
        chk("disc_trdy_h", {31'd0, trdy_n_out}, 32'd1);
        chk("disc_devsel", {31'd0, devsel_n_out}, 32'd0);
        chk("disc_index",  {28'd0, dut.r_index}, 32'd15);
        tick();
        chk("disc_hold_stop", {31'd0, stop_n_out}, 32'd0);
        frame_n = 1'b1;
        tick();
        chk("disc_ta_stop",   {31'd0, stop_n_out}, 32'd1);
        chk("disc_ta_devsel", {31'd0, devsel_n_out}, 32'd1);
        chk("disc_ta_ctl_oe", {31'd0, ctl_oe_n}, 32'd0);
        chk("disc_ta_ad_oe",  {31'd0, ad_oe_n}, 32'd1);
        irdy_n = 1'b1;
        tick();
        chk("disc_release", {31'd0, ctl_oe_n}, 32'd1);

        // Memory write outside the window is not claimed
        addr_phase(32'h2000_0000, CMD_MEM_WR);
        chk("miss_ctl_oe", {31'd0, ctl_oe_n}, 32'd1);
        chk("miss_hit",    {31'd0, hit}, 32'd0);
        chk("miss_state",  {29'd0, dut.r_state}, {29'd0, ST_BUS_BUSY});
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        tick();
        chk("miss_busy_ctl_oe", {31'd0, ctl_oe_n}, 32'd1);
        chk("miss_busy_state",  {29'd0, dut.r_state}, {29'd0, ST_BUS_BUSY});
        irdy_n = 1'b1;
        tick();
        chk("miss_idle", {29'd0, dut.r_state}, {29'd0, ST_IDLE});

        // Config command inside the window is not claimed
        addr_phase(32'h1000_0000, 4'b1011);
        chk("cfg_ctl_oe", {31'd0, ctl_oe_n}, 32'd1);
        chk("cfg_ad_oe",  {31'd0, ad_oe_n}, 32'd1);
        chk("cfg_hit",    {31'd0, hit}, 32'd0);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        tick();
        irdy_n = 1'b1;
        tick();
        chk("cfg_idle", {29'd0, dut.r_state}, {29'd0, ST_IDLE});

        // Reset pulsed during read beat 2
        addr_phase(32'h1000_0004, CMD_MEM_RD);
        irdy_n = 1'b0;
        tick();
        chk("rr_beat1", ad_out, 32'hDEAD_BEEF);
        tick();
        chk("rr_beat2", ad_out, 32'h1111_1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_ad_oe",  {31'd0, ad_oe_n}, 32'd1);
        chk("rr_ctl_oe", {31'd0, ctl_oe_n}, 32'd1);
        chk("rr_state",  {29'd0, dut.r_state}, {29'd0, ST_IDLE});
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        addr_phase(32'h1000_0000, CMD_MEM_WR);
        chk("rr_new_devsel", {31'd0, devsel_n_out}, 32'd0);
        chk("rr_new_hit",    {31'd0, hit}, 32'd1);
        ad_in   = 32'h5A5A_5A5A;
        cbe_n   = 4'h0;
        irdy_n  = 1'b0;
        frame_n = 1'b1;
        tick();
        irdy_n = 1'b1;
        tick();
        chk("rr_new_mem0", dut.u_regfile.r_mem[0], 32'h5A5A_5A5A);
        chk("rr_new_release", {31'd0, ctl_oe_n}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pci_target_ctrl.md
Name: pci_target_ctrl

Overview:
- PCI target (responder) control block. It samples the shared AD/C/BE#/FRAME#/IRDY# bus and decodes memory read and memory write transactions that hit its address window.
- It serves data from and to an internal word-addressed register file.
- It drives DEVSEL#/TRDY#/STOP# and read data as raw values, each paired with an active-low output enable. These pairs feed the TRI_STATE drivers at the pad boundary (control 0 = drive, 1 = high-Z).

Parameters:
- WIDTH, 32, AD bus and data word width.
- BASE_ADDR, 32'h1000_0000, window base; must be aligned to window size.
- DEPTH_LOG2, 4, log2 of register file word count (window = 4*2^DEPTH_LOG2 bytes).

Ports:
- clk  in  1  PCI clock; all sampling on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_n  in  1  FRAME# as sampled from the bus.
- irdy_n  in  1  IRDY# from the bus.
- ad_in  in  WIDTH  AD bus input.
- cbe_n  in  4  C/BE#: command in address phase, byte enables in data phase.
- ad_out  out  WIDTH  read data to the AD tri-state.
- ad_oe_n  out  1  AD driver enable, 0 = drive.
- devsel_n_out  out  1  DEVSEL# value.
- trdy_n_out  out  1  TRDY# value.
- stop_n_out  out  1  STOP# value.
- ctl_oe_n  out  1  shared enable for the DEVSEL#/TRDY#/STOP# drivers, 0 = drive.
- hit  out  1  one-cycle pulse on each claimed transaction (debug/status).

Behaviour:
- Reset: state IDLE, ad_out=0, ad_oe_n=1, devsel_n_out=1, trdy_n_out=1, stop_n_out=1, ctl_oe_n=1, hit=0. Register file is not reset. Reset asserted mid-transaction releases all drivers immediately (async). Returning to IDLE requires no bus handshake.
- Address phase: in IDLE, frame_n==0 with the previous sampled frame_n==1 marks an address phase.
  - Claim condition: ad_in[WIDTH-1:DEPTH_LOG2+2]==BASE_ADDR upper bits and cbe_n is 4'b0110 (mem read) or 4'b0111 (mem write).
  - Claimed: latch word index ad_in[DEPTH_LOG2+1:2] and direction; hit=1 for one cycle.
  - Not claimed: go to BUS_BUSY; stay there until frame_n==1 && irdy_n==1, then IDLE. Other commands (I/O, config) are never claimed.
- States: IDLE, BUS_BUSY, WR_DATA, RD_TA, RD_DATA, TURNAROUND.
- Write (fast decode), cycle A+1 after the address phase: ctl_oe_n=0, devsel_n_out=0, trdy_n_out=0, state WR_DATA.
  - Each edge with irdy_n==0 && trdy_n_out==0 is a data transfer.
  - Write lane i only where cbe_n[i]==0; cbe_n==4'hF is a legal no-op transfer that still advances the index.
- Read, cycle A+1: ctl_oe_n=0, devsel_n_out=0, trdy_n_out=1, ad_oe_n=1 (turnaround), state RD_TA.
  - Cycle A+2: ad_oe_n=0, ad_out=mem[index], trdy_n_out=0, state RD_DATA.
  - Each transfer loads ad_out with the next word in the same cycle, so there is no wait state between burst beats.
- Burst: index increments by 1 per transfer.
  - Transfer on the last word (index == 2^DEPTH_LOG2-1) with frame_n==0: disconnect-with-data. The transfer completes, then the next cycle has stop_n_out=0 and trdy_n_out=1. Hold until frame_n==1, then TURNAROUND.
  - The index never wraps.
- Final transfer (frame_n==1 at the transfer edge): next cycle TURNAROUND with devsel_n_out=1, trdy_n_out=1, stop_n_out=1 driven for one cycle, ad_oe_n=1. The following cycle ctl_oe_n=1 and state IDLE.
- IRDY# wait states (irdy_n==1): hold all outputs and the index; no transfer occurs.
- Master abort/timeout handling is out of scope. The block never asserts STOP# except at the window end.
- Back-to-back transactions: a new address phase is decoded only from IDLE; fast back-to-back is not supported.

Decomposition:
- pci_pkg holds:
  - command constants CMD_MEM_RD=4'b0110 and CMD_MEM_WR=4'b0111;
  - state encoding localparams;
  - byte-lane write helper function.
- One sub-module: pci_target_regfile, a 2^DEPTH_LOG2 x WIDTH array with byte-enable write and combinational read.
- The FSM and decode stay in pci_target_ctrl.

Test Plan:
- Single write to 0x1000_0004, cbe_n=0000, data 0xDEADBEEF, IRDY# ready → DEVSEL#/TRDY# low at A+1; transfer at A+1; TURNAROUND drives 1/1; ctl_oe_n=1 at A+3; mem[1]=0xDEADBEEF.
- Single read of 0x1000_0004 → ad_oe_n=1 at A+1, ad_out=0xDEADBEEF with trdy_n_out=0 at A+2; no driver overlap.
- 3-beat write burst from 0x1000_0008, cbe_n=1100 on beat 2, IRDY# wait inserted before beat 3 → mem[2] full word; mem[3] low 16 bits only; mem[4] written; index holds during the wait.
- Read burst from 0x1000_003C (last word) with FRAME# held → one transfer, then STOP# low with TRDY# high until FRAME# deasserts, then TURNAROUND, then release.
- Address 0x2000_0000 memory write, and config command 4'b1011 inside the window → no enable ever asserted, hit=0, returns to IDLE after FRAME#/IRDY# high.
- rst_n pulsed low during read beat 2 → all *_oe_n=1 immediately; state IDLE; next valid transaction decodes normally.
